// File: rtl/hdmi_frame_timer.sv
// hdmi_frame_timer
//   Pixel-clock front end for the HDMI-in path. Registers the decoded pixel
//   stream, generates line/frame strobes, measures active width and height,
//   and declares lock once the same geometry repeats for LOCK_FRAMES frames.
//
// Ports
//   i_pix_clk, i_reset_n        pixel clock, async active-low reset
//   i_de, i_vsync               data enable, vertical sync (active high)
//   i_r, i_g, i_b               decoded 8-bit pixel
//   o_pix_valid, o_pix_r/g/b    pixel stream, 1-cycle latency
//   o_pix_newline/newframe      first valid pixel of a line / frame
//   o_pix_eol, o_pix_eof        one-cycle line-end / frame-end pulses
//   o_pix_npix, o_pix_nlines    measured active width / height
//   o_locked                    geometry stable
module hdmi_frame_timer #(
  parameter int LGDIM       = 16,
  parameter int LOCK_FRAMES = 3
) (
  input  logic             i_pix_clk,
  input  logic             i_reset_n,
  input  logic             i_de,
  input  logic             i_vsync,
  input  logic [7:0]       i_r,
  input  logic [7:0]       i_g,
  input  logic [7:0]       i_b,
  output logic             o_pix_valid,
  output logic [7:0]       o_pix_r,
  output logic [7:0]       o_pix_g,
  output logic [7:0]       o_pix_b,
  output logic             o_pix_newline,
  output logic             o_pix_newframe,
  output logic             o_pix_eol,
  output logic             o_pix_eof,
  output logic [LGDIM-1:0] o_pix_npix,
  output logic [LGDIM-1:0] o_pix_nlines,
  output logic             o_locked
);

  localparam logic [LGDIM-1:0] DIM_MAX = '1;
  localparam logic [LGDIM-1:0] DIM_ONE = LGDIM'(1);
  localparam logic [3:0]       LOCK_N  = 4'(LOCK_FRAMES);

  logic             de_q, vs_q;
  logic [LGDIM-1:0] xcount_q, xcount_d, ycount_q, ycount_d, line_w_q, line_w_d;
  logic             consistent_q, consistent_d, first_line_q, first_line_d;
  logic             frame_started_q, frame_started_d;
  logic [3:0]       stable_q, stable_d;
  logic [LGDIM-1:0] npix_q, npix_d, nlines_q, nlines_d;
  logic             newframe_d;

  logic             de_rise, de_fall, vs_rise, x_sat, y_sat, width_bad;
  logic [LGDIM-1:0] ycount_upd, line_w_upd;
  logic             first_upd, cons_upd, good, geom_match;
  logic [3:0]       stable_eval;

  assign de_rise = i_de & ~de_q;
  assign de_fall = ~i_de & de_q;
  assign vs_rise = i_vsync & ~vs_q;

  // Width counter sticks at all-ones; every extra high cycle marks the frame bad.
  assign x_sat = i_de & ~de_rise & (xcount_q == DIM_MAX);
  assign y_sat = de_fall & (ycount_q == DIM_MAX);

  // Line-end bookkeeping folded in combinationally so that a line ending on
  // the vsync edge is still counted in the frame being evaluated.
  assign width_bad  = de_fall & ~first_line_q & (xcount_q != line_w_q);
  assign line_w_upd = (de_fall & first_line_q) ? xcount_q : line_w_q;
  assign first_upd  = first_line_q & ~de_fall;
  assign ycount_upd = (de_fall & ~y_sat) ? ycount_q + DIM_ONE : ycount_q;
  assign cons_upd   = consistent_q & ~width_bad & ~y_sat;

  assign good        = cons_upd & ~first_upd & (ycount_upd != '0);
  assign geom_match  = (line_w_upd == npix_q) & (ycount_upd == nlines_q);
  assign stable_eval = (good & geom_match) ?
                       ((stable_q == LOCK_N) ? stable_q : stable_q + 4'd1) :
                       {3'b0, good};

  always_comb begin
    xcount_d        = xcount_q;
    ycount_d        = ycount_upd;
    line_w_d        = line_w_upd;
    first_line_d    = first_upd;
    consistent_d    = cons_upd & ~x_sat;
    stable_d        = stable_q;
    npix_d          = npix_q;
    nlines_d        = nlines_q;
    // A line starting on the vsync edge already belongs to the new frame.
    newframe_d      = de_rise & (frame_started_q | vs_rise);
    frame_started_d = (frame_started_q | vs_rise) & ~de_rise;

    if (de_rise)                 xcount_d = DIM_ONE;
    else if (i_de && !x_sat)     xcount_d = xcount_q + DIM_ONE;

    if (vs_rise) begin
      stable_d     = stable_eval;
      if (good) begin
        npix_d   = line_w_upd;
        nlines_d = ycount_upd;
      end
      ycount_d     = '0;
      first_line_d = 1'b1;
      // Saturation seen on this edge is from a line of the new frame.
      consistent_d = ~x_sat;
    end
  end

  always_ff @(posedge i_pix_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      de_q            <= 1'b0;
      vs_q            <= 1'b0;
      xcount_q        <= '0;
      ycount_q        <= '0;
      line_w_q        <= '0;
      consistent_q    <= 1'b0;
      first_line_q    <= 1'b0;
      frame_started_q <= 1'b0;
      stable_q        <= '0;
      npix_q          <= '0;
      nlines_q        <= '0;
      o_pix_valid     <= 1'b0;
      o_pix_r         <= '0;
      o_pix_g         <= '0;
      o_pix_b         <= '0;
      o_pix_newline   <= 1'b0;
      o_pix_newframe  <= 1'b0;
      o_pix_eol       <= 1'b0;
      o_pix_eof       <= 1'b0;
      o_locked        <= 1'b0;
    end else begin
      de_q            <= i_de;
      vs_q            <= i_vsync;
      xcount_q        <= xcount_d;
      ycount_q        <= ycount_d;
      line_w_q        <= line_w_d;
      consistent_q    <= consistent_d;
      first_line_q    <= first_line_d;
      frame_started_q <= frame_started_d;
      stable_q        <= stable_d;
      npix_q          <= npix_d;
      nlines_q        <= nlines_d;
      o_pix_valid     <= i_de;
      o_pix_r         <= i_r;
      o_pix_g         <= i_g;
      o_pix_b         <= i_b;
      o_pix_newline   <= de_rise;
      o_pix_newframe  <= newframe_d;
      o_pix_eol       <= de_fall;
      o_pix_eof       <= vs_rise;
      o_locked        <= (stable_d == LOCK_N);
    end
  end

  assign o_pix_npix   = npix_q;
  assign o_pix_nlines = nlines_q;

endmodule

// File: tb/tb_hdmi_frame_timer.sv
// Bench for hdmi_frame_timer (LGDIM=8 so width saturation is reachable).
// A table of short vectors checks strobe alignment, directed frame sequences
// cover lock/unlock, height change, coincident eol/eof, async reset and
// saturation, and randomized frames are checked every cycle against a
// frame-level model that keeps each frame's line widths in a queue.
module tb_hdmi_frame_timer;
  localparam int LGDIM = 8;
  localparam int LOCK  = 3;
  localparam int MAXV  = 255;

  logic       clk = 1'b0, rst_n = 1'b1, de = 1'b0, vs = 1'b0;
  logic [7:0] r = '0, g = '0, b = '0;
  logic       o_valid, o_nl, o_nf, o_eol, o_eof, o_locked;
  logic [7:0] o_r, o_g, o_b, o_npix, o_nlines;

  hdmi_frame_timer #(.LGDIM(LGDIM), .LOCK_FRAMES(LOCK)) dut (
    .i_pix_clk(clk), .i_reset_n(rst_n), .i_de(de), .i_vsync(vs),
    .i_r(r), .i_g(g), .i_b(b),
    .o_pix_valid(o_valid), .o_pix_r(o_r), .o_pix_g(o_g), .o_pix_b(o_b),
    .o_pix_newline(o_nl), .o_pix_newframe(o_nf), .o_pix_eol(o_eol),
    .o_pix_eof(o_eof), .o_pix_npix(o_npix), .o_pix_nlines(o_nlines),
    .o_locked(o_locked)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  // ---------------- reference model ----------------
  int  m_pde, m_pvs, m_cnt, m_bad, m_open, m_fstart, m_npix, m_nlines, m_stable;
  int  m_lines[$];
  logic [45:0] exp_vec;

  function automatic logic [45:0] dut_vec();
    return {o_valid, o_r, o_g, o_b, o_nl, o_nf, o_eol, o_eof, o_npix, o_nlines, o_locked};
  endfunction

  task automatic model_reset();
    m_pde = 0; m_pvs = 0; m_cnt = 0; m_bad = 0; m_open = 0; m_fstart = 0;
    m_npix = 0; m_nlines = 0; m_stable = 0;
    m_lines.delete();
    exp_vec = '0;
  endtask

  task automatic model_step(input logic di, vi, input logic [7:0] ri, gi, bi);
    bit rise, fall, vr, sat, nf, good, eq;
    int w, h;
    rise = di && !m_pde; fall = !di && m_pde; vr = vi && !m_pvs;
    sat  = di && !rise && (m_cnt >= MAXV);
    if (rise) m_cnt = 1;
    else if (di) m_cnt++;
    if (fall) m_lines.push_back((m_cnt > MAXV) ? MAXV : m_cnt);
    nf = rise && (m_fstart != 0 || vr);
    m_fstart = ((m_fstart != 0 || vr) && !rise) ? 1 : 0;
    if (vr) begin
      h  = m_lines.size();
      eq = 1;
      foreach (m_lines[i]) if (m_lines[i] != m_lines[0]) eq = 0;
      good = (m_open != 0) && (m_bad == 0) && h > 0 && h <= MAXV && eq;
      w = (h > 0) ? m_lines[0] : 0;
      if (good && w == m_npix && h == m_nlines)
        m_stable = (m_stable >= LOCK) ? LOCK : m_stable + 1;
      else
        m_stable = good ? 1 : 0;
      if (good) begin m_npix = w; m_nlines = h; end
      m_lines.delete();
      m_bad  = sat;
      m_open = 1;
    end else if (sat) m_bad = 1;
    m_pde = di; m_pvs = vi;
    exp_vec = {di, ri, gi, bi, rise, nf, fall, vr, 8'(m_npix), 8'(m_nlines),
               (m_stable == LOCK)};
  endtask

  // ---------------- check helpers ----------------
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
    end
  endtask

  task automatic cyc(input logic di, vi);
    de = di; vs = vi;
    r = 8'($urandom); g = 8'($urandom); b = 8'($urandom);
    model_step(di, vi, r, g, b);
    @(posedge clk); #1;
    chk("model", 64'(dut_vec()), 64'(exp_vec));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("reset_outputs", 64'(dut_vec()), 64'd0);
    model_reset();
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b1;
  endtask

  task automatic frame(input int h, w, badl, badw, input bit simul);
    for (int l = 0; l < h; l++) begin
      cyc(0, 0); cyc(0, 0);
      for (int k = 0; k < ((l == badl) ? badw : w); k++) cyc(1, 0);
    end
    if (simul) begin
      cyc(0, 1);
      chk("simul_eol_eof", 64'({o_eol, o_eof}), 64'b11);
    end else begin
      cyc(0, 0); cyc(0, 1);
    end
    cyc(0, 1); cyc(0, 0);
  endtask

  task automatic geom(input string nm, input int np, nl, lk);
    chk({nm, "_npix"},   64'(o_npix),   64'(np));
    chk({nm, "_nlines"}, 64'(o_nlines), 64'(nl));
    chk({nm, "_locked"}, 64'(o_locked), 64'(lk));
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    logic de, vs; logic [7:0] px;
    logic valid, nl, nf, eol, eof;
  } vec_t;
  vec_t tbl[12];

  initial begin
    int w, h, bl, md;
    tbl[0]  = '{0, 0, 8'h00, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 0, 8'h11, 1, 1, 0, 0, 0};  // no newframe before first vsync
    tbl[2]  = '{1, 0, 8'h22, 1, 0, 0, 0, 0};
    tbl[3]  = '{0, 0, 8'h33, 0, 0, 0, 1, 0};
    tbl[4]  = '{0, 1, 8'h44, 0, 0, 0, 0, 1};
    tbl[5]  = '{0, 1, 8'h55, 0, 0, 0, 0, 0};
    tbl[6]  = '{0, 0, 8'h66, 0, 0, 0, 0, 0};
    tbl[7]  = '{1, 0, 8'h77, 1, 1, 1, 0, 0};
    tbl[8]  = '{1, 0, 8'h88, 1, 0, 0, 0, 0};
    tbl[9]  = '{0, 0, 8'h99, 0, 0, 0, 1, 0};
    tbl[10] = '{1, 0, 8'haa, 1, 1, 0, 0, 0};
    tbl[11] = '{0, 1, 8'hbb, 0, 0, 0, 1, 1};

    model_reset();
    #1 rst_n = 1'b0;
    #1 chk("reset_state", 64'(dut_vec()), 64'd0);
    @(posedge clk); #3 rst_n = 1'b1;

    foreach (tbl[i]) begin
      de = tbl[i].de; vs = tbl[i].vs; r = tbl[i].px; g = ~tbl[i].px; b = tbl[i].px ^ 8'h5a;
      model_step(de, vs, r, g, b);
      @(posedge clk); #1;
      chk($sformatf("tbl%0d", i),
          64'({o_valid, o_nl, o_nf, o_eol, o_eof, o_r, o_g}),
          64'({tbl[i].valid, tbl[i].nl, tbl[i].nf, tbl[i].eol, tbl[i].eof,
               tbl[i].px, ~tbl[i].px}));
    end

    // ideal 4x8 frames: lock one cycle after the 4th vsync edge
    do_reset();
    cyc(0, 0); cyc(0, 1); cyc(0, 0);
    frame(4, 8, -1, 0, 0); geom("ideal1", 8, 4, 0);
    frame(4, 8, -1, 0, 0); geom("ideal2", 8, 4, 0);
    frame(4, 8, -1, 0, 0); geom("ideal3", 8, 4, 1);

    // one short line drops lock, measurements held
    frame(4, 8, 2, 7, 0);  geom("badline", 8, 4, 0);
    frame(4, 8, -1, 0, 0); frame(4, 8, -1, 0, 0); geom("relock2", 8, 4, 0);
    frame(4, 8, -1, 0, 0); geom("relock3", 8, 4, 1);

    // height change while locked
    frame(5, 8, -1, 0, 0); geom("h5_1", 8, 5, 0);
    frame(5, 8, -1, 0, 0); geom("h5_2", 8, 5, 0);
    frame(5, 8, -1, 0, 0); geom("h5_3", 8, 5, 1);

    // last line ends on the vsync edge and is still counted
    frame(4, 8, -1, 0, 1); geom("simul", 8, 4, 0);

    // async reset in the middle of a line
    cyc(0, 0); cyc(1, 0); cyc(1, 0);
    do_reset();
    cyc(1, 0); cyc(1, 0); cyc(0, 0);
    chk("post_reset_nf", 64'(o_nf), 64'd0);
    frame(4, 8, -1, 0, 0); geom("post_reset_f1", 0, 0, 0);
    frame(4, 8, -1, 0, 0); geom("post_reset_f2", 8, 4, 0);
    frame(4, 8, -1, 0, 0); frame(4, 8, -1, 0, 0); geom("post_reset_lock", 8, 4, 1);

    // line held high for 256 cycles saturates the width counter
    frame(4, 8, 1, 256, 0); geom("saturate", 8, 4, 0);

    // randomized frames
    w = 8; h = 4;
    repeat (40) begin
      if ($urandom_range(0, 3) == 0) begin
        w = $urandom_range(1, 12); h = $urandom_range(1, 5);
      end
      bl = ($urandom_range(0, 5) == 0) ? $urandom_range(0, h - 1) : -1;
      for (int l = 0; l < h; l++) begin
        repeat ($urandom_range(1, 3)) cyc(0, 0);
        for (int k = 0; k < ((l == bl) ? w + 1 : w); k++) cyc(1, 0);
      end
      md = $urandom_range(0, 7);
      if (md == 0) begin
        // a line straddles the vsync edge and belongs to the next frame
        cyc(0, 0); cyc(1, 0); cyc(1, 1); cyc(1, 1); cyc(0, 0);
      end else if (md < 3) begin
        cyc(0, 1); cyc(0, 1); cyc(0, 0);
      end else begin
        cyc(0, 0); cyc(0, 1); cyc($urandom_range(0, 1) == 1, 1); cyc(0, 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
